// File: rtl/ysyx_22050019_mem_arbiter.sv
// ysyx_22050019_mem_arbiter: round-robin IFU/LSU arbiter onto a single memory port,
// one transaction outstanding, with a response timeout.
`default_nettype none

module ysyx_22050019_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rsp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_we,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  logic               owner;       // 0 = IFU, 1 = LSU
  logic               last_grant;  // 0 = IFU, 1 = LSU
  logic [CNT_W-1:0]   cnt;

  logic grant_ifu;
  logic grant_lsu;
  logic accept;
  logic rsp_fire;

  // On a tie the master that did not win last time is granted.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_ifu = last_grant;
        grant_lsu = ~last_grant;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  assign accept        = grant_ifu | grant_lsu;
  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // A real response in the timeout cycle takes precedence, so err only when no data came.
  assign rsp_fire      = (state == S_RESP) && (mem_rsp_valid || (cnt == CNT_LAST));
  assign ifu_rsp_valid = rsp_fire & ~owner;
  assign lsu_rsp_valid = rsp_fire & owner;
  assign ifu_rsp_err   = ifu_rsp_valid & ~mem_rsp_valid;
  assign lsu_rsp_err   = lsu_rsp_valid & ~mem_rsp_valid;
  assign ifu_rdata     = (ifu_rsp_valid && mem_rsp_valid) ? mem_rdata : '0;
  assign lsu_rdata     = (lsu_rsp_valid && mem_rsp_valid) ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_REQ;
            owner         <= grant_lsu;
            last_grant    <= grant_lsu;
            mem_req_valid <= 1'b1;
            mem_we        <= grant_lsu & lsu_we;
            mem_addr      <= grant_lsu ? lsu_addr : ifu_addr;
            mem_wdata     <= grant_lsu ? lsu_wdata : '0;
            mem_wmask     <= grant_lsu ? lsu_wmask : '0;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_RESP;
            cnt           <= '0;
            mem_req_valid <= 1'b0;
          end
        end
        S_RESP: begin
          cnt <= cnt + 1'b1;
          if (rsp_fire) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// tb_ysyx_22050019_mem_arbiter: directed stimulus with queue-based scoreboard for
// grants, memory requests and routed responses.
`default_nettype none

module tb_ysyx_22050019_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ifu_req_valid = 1'b0;
  logic          ifu_req_ready;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_rsp_valid;
  logic [DW-1:0] ifu_rdata;
  logic          ifu_rsp_err;
  logic          lsu_req_valid = 1'b0;
  logic          lsu_req_ready;
  logic          lsu_we = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic [MW-1:0] lsu_wmask = '0;
  logic          lsu_rsp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_rsp_err;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_wmask;
  logic          mem_rsp_valid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  ysyx_22050019_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          owner;
    logic [DW-1:0] data;
    logic          err;
    int            cyc;
  } rsp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mem_q[$];
  logic  grant_q[$];
  rsp_t  e;
  mreq_t m;
  logic  g;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [199:0] got, input logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {ifu_req_ready, lsu_req_ready, ifu_rsp_valid, ifu_rsp_err,
                         lsu_rsp_valid, lsu_rsp_err, mem_req_valid, mem_we, mem_wmask}, '0);
    chk({tag, "_addr"}, mem_addr, '0);
    chk({tag, "_wdata"}, mem_wdata, '0);
    chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, '0);
  endtask

  // Scoreboard monitor: grants, memory request payload (every cycle it is valid) and responses.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_exclusive", ifu_req_ready & lsu_req_ready, 1'b0);
      if (ifu_req_ready || lsu_req_ready) begin
        if (grant_q.size() == 0) chk("grant_unexpected", 1'b1, 1'b0);
        else begin
          g = grant_q.pop_front();
          chk("grant_owner", lsu_req_ready, g);
        end
      end
      if (mem_req_valid) begin
        if (mem_q.size() == 0) chk("mem_req_unexpected", 1'b1, 1'b0);
        else begin
          m = mem_q[0];
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wmask", mem_wmask, m.wmask);
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
          if (mem_req_ready) void'(mem_q.pop_front());
        end
      end
      if (ifu_rsp_valid && lsu_rsp_valid) chk("rsp_exclusive", 1'b1, 1'b0);
      else if (ifu_rsp_valid || lsu_rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1'b1, 1'b0);
        else begin
          e = rsp_q.pop_front();
          chk("rsp_owner", lsu_rsp_valid, e.owner);
          chk("rsp_data", lsu_rsp_valid ? lsu_rdata : ifu_rdata, e.data);
          chk("rsp_err", lsu_rsp_valid ? lsu_rsp_err : ifu_rsp_err, e.err);
          chk("rsp_cycle", cyc, e.cyc);
        end
      end
      if (!ifu_rsp_valid) chk("ifu_quiet", {ifu_rdata, ifu_rsp_err}, '0);
      if (!lsu_rsp_valid) chk("lsu_quiet", {lsu_rdata, lsu_rsp_err}, '0);
    end
  end

  task automatic ifu_req(input logic [AW-1:0] a);
    int n = 0;
    ifu_req_valid = 1'b1;
    ifu_addr = a;
    #1;
    while (!ifu_req_ready && n < 50) begin step(); n++; end
    if (!ifu_req_ready) chk("ifu_ready_wait", 1'b0, 1'b1);
    else step();
    ifu_req_valid = 1'b0;
    ifu_addr = '0;
  endtask

  task automatic lsu_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [MW-1:0] wm);
    int n = 0;
    lsu_req_valid = 1'b1;
    lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wmask = wm;
    #1;
    while (!lsu_req_ready && n < 50) begin step(); n++; end
    if (!lsu_req_ready) chk("lsu_ready_wait", 1'b0, 1'b1);
    else step();
    lsu_req_valid = 1'b0;
    lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
  endtask

  // Both masters hold valid for n accepts; IFU reads a0, LSU writes a1.
  task automatic both_req(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] wd, input logic [MW-1:0] wm);
    ifu_req_valid = 1'b1; ifu_addr = a0;
    lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_addr = a1; lsu_wdata = wd; lsu_wmask = wm;
    #1;
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!(ifu_req_ready || lsu_req_ready) && w < 50) begin step(); w++; end
      if (!(ifu_req_ready || lsu_req_ready)) chk("both_ready_wait", 1'b0, 1'b1);
      step();
    end
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
  endtask

  // mode 0: respond after sdly RESP cycles; 1: never respond, then late response;
  // 2: reset in RESP, then a stray response.
  task automatic do_mem(input int rdly, input int sdly, input logic [DW-1:0] data,
                        input logic owner, input int mode);
    int n = 0;
    while (!mem_req_valid && n < 50) begin step(); n++; end
    if (!mem_req_valid) begin
      chk("mem_req_wait", 1'b0, 1'b1);
      return;
    end
    repeat (rdly) step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    if (mode == 0) begin
      rsp_q.push_back('{owner, data, 1'b0, cyc + sdly});
      repeat (sdly) step();
    end else if (mode == 1) begin
      rsp_q.push_back('{owner, '0, 1'b1, cyc + TO - 1});
      repeat (TO + 1) step();
    end else begin
      step();
      rst = 1'b1;
      #1;
      check_all_zero("rst_mid");
      step();
      rst = 1'b0;
      #1;
      check_all_zero("after_rst_mid");
    end
    mem_rsp_valid = 1'b1;
    mem_rdata = data;
    step();
    mem_rsp_valid = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) step();
    check_all_zero("in_reset");
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Single IFU read
    grant_q.push_back(1'b0);
    mem_q.push_back('{1'b0, 64'h8000_0000, 64'h0, 8'h00});
    fork
      ifu_req(64'h8000_0000);
      do_mem(0, 0, 64'h1234, 1'b0, 0);
    join

    // LSU write with ready held off for 3 cycles
    grant_q.push_back(1'b1);
    mem_q.push_back('{1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F});
    fork
      lsu_req(1'b1, 64'h8000_0100, 64'hDEAD_BEEF, 8'h0F);
      do_mem(3, 0, 64'h0, 1'b1, 0);
    join

    // Four back-to-back ties alternate IFU, LSU, IFU, LSU
    for (int i = 0; i < 4; i++) begin
      grant_q.push_back(i[0]);
      if (i[0]) mem_q.push_back('{1'b1, 64'h8000_2000, 64'h1111_2222_3333_4444, 8'hFF});
      else      mem_q.push_back('{1'b0, 64'h8000_1000, 64'h0, 8'h00});
    end
    fork
      both_req(4, 64'h8000_1000, 64'h8000_2000, 64'h1111_2222_3333_4444, 8'hFF);
      for (int j = 0; j < 4; j++) do_mem(0, j, 64'hA000 + 64'(j), j[0], 0);
    join

    // Timeout with a late response two cycles after the error pulse
    grant_q.push_back(1'b0);
    mem_q.push_back('{1'b0, 64'h8000_0300, 64'h0, 8'h00});
    fork
      ifu_req(64'h8000_0300);
      do_mem(0, 0, 64'hBAD0, 1'b0, 1);
    join

    // Response arriving in the timeout cycle wins
    grant_q.push_back(1'b1);
    mem_q.push_back('{1'b0, 64'h8000_0400, 64'h0, 8'h3C});
    fork
      lsu_req(1'b0, 64'h8000_0400, 64'h0, 8'h3C);
      do_mem(0, TO - 1, 64'hCAFE_F00D, 1'b1, 0);
    join

    // IFU transaction abandoned by reset; last grant was IFU before reset
    grant_q.push_back(1'b0);
    mem_q.push_back('{1'b0, 64'h8000_0500, 64'h0, 8'h00});
    fork
      ifu_req(64'h8000_0500);
      do_mem(0, 0, 64'hBAD1, 1'b0, 2);
    join

    // After reset the first tie must go to IFU
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    mem_q.push_back('{1'b0, 64'h8000_0600, 64'h0, 8'h00});
    mem_q.push_back('{1'b1, 64'h8000_0700, 64'h5555_6666, 8'hF0});
    fork
      both_req(2, 64'h8000_0600, 64'h8000_0700, 64'h5555_6666, 8'hF0);
      begin
        do_mem(0, 0, 64'h600D, 1'b0, 0);
        do_mem(1, 1, 64'h700D, 1'b1, 0);
      end
    join

    repeat (5) step();
    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    chk("grant_q_empty", grant_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
